// File: rtl/alu_param.sv
// Parameterised ALU: single-cycle arithmetic/logic/shift operations plus iterative
// shift-add multiply and restoring divide, with power-down abort and output isolation.

module alu_param #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_pwr_en,
  input  logic             iso_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] workHi_q, workHi_d;
  logic [WIDTH-1:0] workLo_q, workLo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] resultHi_q, resultHi_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH:0]   addFull, subFull;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quickRes, quickHi;
  logic             quickCarry, quickOvf, quickDiv0;
  logic [3:0]       quickFlags;

  // Single-cycle results come straight from the live inputs on the accepting edge.
  always_comb begin
    addFull    = {1'b0, a} + {1'b0, b};
    subFull    = {1'b0, a} - {1'b0, b};
    shamt      = b[SHW-1:0];
    quickRes   = '0;
    quickHi    = '0;
    quickCarry = 1'b0;
    quickOvf   = 1'b0;
    quickDiv0  = 1'b0;
    case (opcode)
      OP_ADD: begin
        quickRes   = addFull[WIDTH-1:0];
        quickCarry = addFull[WIDTH];
        quickOvf   = (a[WIDTH-1] == b[WIDTH-1]) && (addFull[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        quickRes   = subFull[WIDTH-1:0];
        quickCarry = subFull[WIDTH];
        quickOvf   = (a[WIDTH-1] != b[WIDTH-1]) && (subFull[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  quickRes = a & b;
      OP_OR:   quickRes = a | b;
      OP_XOR:  quickRes = a ^ b;
      OP_NOR:  quickRes = ~(a | b);
      OP_SLL:  quickRes = a << shamt;
      OP_XNOR: quickRes = ~(a ^ b);
      OP_SRL:  quickRes = a >> shamt;
      OP_SRA:  quickRes = WIDTH'($signed(a) >>> shamt);
      OP_DIV: begin
        quickHi   = a;
        quickDiv0 = 1'b1;
      end
      default: ;
    endcase
    quickFlags = {quickDiv0, quickOvf, quickCarry, quickRes == '0};
  end

  logic [WIDTH:0]   mulSum, divShift;
  logic             divFits;
  logic [WIDTH-1:0] divDiff, stepHi, stepLo;

  // One iteration: MUL keeps {acc, multiplier}, DIV keeps {remainder, quotient}.
  always_comb begin
    mulSum   = {1'b0, workHi_q} + (workLo_q[0] ? {1'b0, opA_q} : '0);
    divShift = {workHi_q, workLo_q[WIDTH-1]};
    divFits  = divShift >= {1'b0, opB_q};
    divDiff  = WIDTH'(divShift - {1'b0, opB_q});
    if (op_q == OP_MUL) begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], workLo_q[WIDTH-1:1]};
    end else begin
      stepHi = divFits ? divDiff : divShift[WIDTH-1:0];
      stepLo = {workLo_q[WIDTH-2:0], divFits};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    op_d       = op_q;
    workHi_d   = workHi_q;
    workLo_d   = workLo_q;
    result_d   = result_q;
    resultHi_d = resultHi_q;
    flags_d    = flags_q;
    if (!alu_pwr_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !iso_en) begin
            opA_d = a;
            opB_d = b;
            op_d  = opcode;
            cnt_d = '0;
            if ((opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0))) begin
              state_d  = EXEC;
              workHi_d = '0;
              workLo_d = (opcode == OP_MUL) ? b : a;
            end else begin
              state_d    = DONE;
              result_d   = quickRes;
              resultHi_d = quickHi;
              flags_d    = quickFlags;
            end
          end
        end
        EXEC: begin
          workHi_d = stepHi;
          workLo_d = stepLo;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d    = DONE;
            cnt_d      = '0;
            result_d   = stepLo;
            resultHi_d = stepHi;
            flags_d    = (op_q == OP_MUL) ? {1'b0, stepHi != '0, 1'b0, stepLo == '0}
                                          : {3'b000, stepLo == '0};
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      op_q       <= '0;
      workHi_q   <= '0;
      workLo_q   <= '0;
      result_q   <= '0;
      resultHi_q <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      op_q       <= op_d;
      workHi_q   <= workHi_d;
      workLo_q   <= workLo_d;
      result_q   <= result_d;
      resultHi_q <= resultHi_d;
      flags_q    <= flags_d;
    end
  end

  // Isolation clamps every visible output without touching internal state.
  assign in_ready  = (state_q == IDLE) && alu_pwr_en && !iso_en;
  assign out_valid = (state_q == DONE) && !iso_en;
  assign busy      = (state_q == EXEC) && !iso_en;
  assign result    = iso_en ? '0 : result_q;
  assign result_hi = iso_en ? '0 : resultHi_q;
  assign flags     = iso_en ? '0 : flags_q;

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param: arithmetic reference model with a per-cycle
// comparator, directed literal checks and randomized transactions.

module tb_alu_param;

  localparam int    W        = 16;
  localparam int    MAX_WAIT = 100;
  localparam longint SMAX    = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN    = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         alu_pwr_en = 1'b1;
  logic         iso_en = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   opcode = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result, result_hi;
  logic [3:0]   flags;

  int nCompared = 0;
  int nMismatched = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  alu_param #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .flags      (flags),
    .busy       (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference results computed with plain integer arithmetic.
  function automatic void refAlu(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                 input logic [3:0] rop, output logic [W-1:0] res,
                                 output logic [W-1:0] hi, output logic [3:0] fl);
    longint ua, ub, sa, sb, t;
    logic c, v, d;
    ua = longint'(ra);
    ub = longint'(rb);
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    res = '0; hi = '0; c = 1'b0; v = 1'b0; d = 1'b0;
    case (rop)
      4'h0: begin
        t = ua + ub; res = t[W-1:0]; c = (t >> W) != 0;
        t = sa + sb; v = (t > SMAX) || (t < SMIN);
      end
      4'h1: begin
        t = ua - ub; res = t[W-1:0]; c = ua < ub;
        t = sa - sb; v = (t > SMAX) || (t < SMIN);
      end
      4'h2: res = ra & rb;
      4'h3: res = ra | rb;
      4'h4: res = ra ^ rb;
      4'h5: res = ~(ra | rb);
      4'h6: begin t = ua << rb[3:0]; res = t[W-1:0]; end
      4'h7: res = ~(ra ^ rb);
      4'h8: begin t = ua * ub; res = t[W-1:0]; hi = t[2*W-1:W]; v = (hi != 0); end
      4'h9: begin
        if (ub == 0) begin res = '0; hi = ra; d = 1'b1; end
        else begin t = ua / ub; res = t[W-1:0]; t = ua % ub; hi = t[W-1:0]; end
      end
      4'hA: begin t = ua >> rb[3:0]; res = t[W-1:0]; end
      4'hB: begin t = sa >>> rb[3:0]; res = t[W-1:0]; end
      default: ;
    endcase
    fl = {d, v, c, res == '0};
  endfunction

  function automatic int expLatency(input logic [W-1:0] fb, input logic [3:0] fop);
    return ((fop == 4'h8) || ((fop == 4'h9) && (fb != '0))) ? W + 1 : 1;
  endfunction

  // Transaction-level model: which phase the block is in and the response it owes.
  typedef enum {M_IDLE, M_WORK, M_DONE} mphase_t;
  mphase_t      mPhase = M_IDLE;
  int           mLeft = 0;
  logic [W-1:0] mRes = '0, mHi = '0, pRes = '0, pHi = '0;
  logic [3:0]   mFl = '0, pFl = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase = M_IDLE; mLeft = 0; mRes = '0; mHi = '0; mFl = '0;
    end else if (!alu_pwr_en) begin
      mPhase = M_IDLE;
    end else begin
      case (mPhase)
        M_IDLE: if (in_valid && !iso_en) begin
          refAlu(a, b, opcode, pRes, pHi, pFl);
          if (expLatency(b, opcode) == 1) begin
            mPhase = M_DONE; mRes = pRes; mHi = pHi; mFl = pFl;
          end else begin
            mPhase = M_WORK; mLeft = W;
          end
        end
        M_WORK: begin
          mLeft--;
          if (mLeft == 0) begin
            mPhase = M_DONE; mRes = pRes; mHi = pHi; mFl = pFl;
          end
        end
        M_DONE: if (out_ready) mPhase = M_IDLE;
        default: mPhase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ready",  64'(in_ready),  64'(mPhase == M_IDLE && alu_pwr_en && !iso_en));
      checkOutput("out_valid", 64'(out_valid), 64'(mPhase == M_DONE && !iso_en));
      checkOutput("busy",      64'(busy),      64'(mPhase == M_WORK && !iso_en));
      checkOutput("result",    64'(result),    64'(iso_en ? '0 : mRes));
      checkOutput("result_hi", 64'(result_hi), 64'(iso_en ? '0 : mHi));
      checkOutput("flags",     64'(flags),     64'(iso_en ? 4'h0 : mFl));
    end
  end

  // Drives one request for a single cycle, then scrambles the operand inputs.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic [3:0] top);
    a = ta; b = tb; opcode = top; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); opcode = 4'($urandom);
  endtask

  task automatic waitValid(input int expLat, output int busyCnt);
    int cycles = 1;
    busyCnt = 0;
    while (!out_valid && cycles < MAX_WAIT) begin
      if (busy) busyCnt++;
      @(posedge clk); #2;
      cycles++;
    end
    checkOutput("latency", 64'(cycles), 64'(expLat));
  endtask

  task automatic releaseResult(input bit sneak);
    out_ready = 1'b1;
    if (sneak && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); opcode = 4'($urandom);
    end
    @(posedge clk); #2;
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bc, hold, pause;
    logic [W-1:0] ra, rb;
    logic [3:0] rop;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset busy",      64'(busy),      64'(0));
    checkOutput("reset result",    64'(result),    64'(0));
    checkOutput("reset result_hi", 64'(result_hi), 64'(0));
    checkOutput("reset flags",     64'(flags),     64'(0));
    #1;
    rst_n = 1'b1;
    checkEn = 1'b1;
    @(posedge clk); #2;
    checkOutput("in_ready after reset", 64'(in_ready), 64'(1));

    applyStimulus(16'hFFFF, 16'h0001, 4'h0);
    waitValid(1, bc);
    checkOutput("ADD result", 64'(result), 64'(16'h0000));
    checkOutput("ADD flags",  64'(flags),  64'(4'b0011));
    releaseResult(1'b0);

    applyStimulus(16'h1234, 16'h0100, 4'h8);
    waitValid(17, bc);
    checkOutput("MUL busy cycles", 64'(bc),        64'(16));
    checkOutput("MUL result",      64'(result),    64'(16'h3400));
    checkOutput("MUL result_hi",   64'(result_hi), 64'(16'h0012));
    checkOutput("MUL flags",       64'(flags),     64'(4'b0100));
    repeat (5) begin
      @(posedge clk); #2;
      checkOutput("hold result",    64'(result),    64'(16'h3400));
      checkOutput("hold out_valid", 64'(out_valid), 64'(1));
      checkOutput("hold in_ready",  64'(in_ready),  64'(0));
    end
    releaseResult(1'b0);
    checkOutput("idle in_ready",  64'(in_ready),  64'(1));
    checkOutput("idle out_valid", 64'(out_valid), 64'(0));

    applyStimulus(16'h0064, 16'h0007, 4'h9);
    waitValid(17, bc);
    checkOutput("DIV quotient",  64'(result),    64'(16'h000E));
    checkOutput("DIV remainder", 64'(result_hi), 64'(16'h0002));
    releaseResult(1'b0);

    applyStimulus(16'h00AB, 16'h0000, 4'h9);
    waitValid(1, bc);
    checkOutput("DIV0 result",    64'(result),    64'(16'h0000));
    checkOutput("DIV0 result_hi", 64'(result_hi), 64'(16'h00AB));
    checkOutput("DIV0 flags",     64'(flags),     64'(4'b1001));
    iso_en = 1'b1;
    #1;
    checkOutput("iso out_valid", 64'(out_valid), 64'(0));
    checkOutput("iso result_hi", 64'(result_hi), 64'(0));
    checkOutput("iso flags",     64'(flags),     64'(0));
    checkOutput("iso in_ready",  64'(in_ready),  64'(0));
    repeat (2) @(posedge clk);
    #2;
    iso_en = 1'b0;
    #1;
    checkOutput("unisolated out_valid", 64'(out_valid), 64'(1));
    checkOutput("unisolated result_hi", 64'(result_hi), 64'(16'h00AB));
    checkOutput("unisolated flags",     64'(flags),     64'(4'b1001));
    releaseResult(1'b0);

    applyStimulus(16'h0003, 16'h0004, 4'h0);
    waitValid(1, bc);
    checkOutput("ADD small result", 64'(result), 64'(16'h0007));
    releaseResult(1'b0);
    applyStimulus(16'h00FF, 16'h00FF, 4'h8);
    repeat (4) @(posedge clk);
    #2;
    alu_pwr_en = 1'b0;
    @(posedge clk); #2;
    checkOutput("abort busy",      64'(busy),      64'(0));
    checkOutput("abort out_valid", 64'(out_valid), 64'(0));
    checkOutput("abort result",    64'(result),    64'(16'h0007));
    in_valid = 1'b1; a = 16'h0005; b = 16'h0005; opcode = 4'h0;
    @(posedge clk); #2;
    checkOutput("powered-down in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    @(posedge clk); #2;
    alu_pwr_en = 1'b1;
    @(posedge clk); #2;
    checkOutput("repowered in_ready", 64'(in_ready), 64'(1));
    checkOutput("repowered result",   64'(result),   64'(16'h0007));

    applyStimulus(16'hFFFF, 16'h0003, 4'h9);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-DIV reset result",    64'(result),    64'(0));
    checkOutput("mid-DIV reset busy",      64'(busy),      64'(0));
    checkOutput("mid-DIV reset out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      else if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 20));
      applyStimulus(ra, rb, rop);
      if ($urandom_range(0, 9) == 0) begin
        pause = $urandom_range(0, 20);
        for (int k = 0; k < pause; k++) begin @(posedge clk); #2; end
        alu_pwr_en = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        alu_pwr_en = 1'b1;
      end else begin
        waitValid(expLatency(rb, rop), bc);
        hold = $urandom_range(0, 3);
        for (int k = 0; k < hold; k++) begin @(posedge clk); #2; end
        if ($urandom_range(0, 3) == 0) begin
          iso_en = 1'b1;
          @(posedge clk); #2;
          iso_en = 1'b0;
        end
        releaseResult(1'b1);
      end
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal values 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived and not overridden.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port alu_pwr_en  in  1  power enable; low = domain powered down.
REQ-006 Port iso_en  in  1  output isolation enable.
REQ-007 Port in_valid  in  1  request valid.
REQ-008 Port in_ready  out  1  block can accept a request.
REQ-009 Port a  in  WIDTH  operand A.
REQ-010 Port b  in  WIDTH  operand B.
REQ-011 Port opcode  in  4  operation select.
REQ-012 Port out_valid  out  1  response valid.
REQ-013 Port out_ready  in  1  consumer accepts response.
REQ-014 Port result  out  WIDTH  primary result, or MUL low half, or DIV quotient.
REQ-015 Port result_hi  out  WIDTH  MUL high half or DIV remainder; 0 for all other ops.
REQ-016 Port flags  out  4  {div0, ovf, carry, zero}.
REQ-017 Port busy  out  1  multi-cycle operation in progress.

Function
REQ-018 FSM states SHALL be IDLE, EXEC and DONE.
REQ-019 in_ready SHALL be 1 only when state is IDLE and alu_pwr_en is 1; acceptance = in_valid & in_ready.
REQ-020 On acceptance a, b and opcode SHALL be captured; later input changes SHALL NOT affect the operation in flight.
REQ-021 Opcodes 0000-0111 (ADD, SUB, AND, OR, XOR, NOR, SLL by b[SHW-1:0], XNOR), 1010 (SRL), 1011 (SRA) and 1111 SHALL complete in one cycle: IDLE->DONE, out_valid high the cycle after acceptance.
REQ-022 Opcode 1000 MUL SHALL be unsigned shift-add over exactly WIDTH EXEC cycles, producing a 2*WIDTH-bit product split as {result_hi, result}.
REQ-023 Opcode 1001 DIV SHALL be unsigned restoring division over exactly WIDTH EXEC cycles: result = quotient, result_hi = remainder.
REQ-024 MUL/DIV latency SHALL be WIDTH+1 cycles from the acceptance edge to out_valid high; busy SHALL be 1 exactly in EXEC.
REQ-025 DIV with b==0 SHALL skip EXEC and go to DONE the next cycle with result=0, result_hi=a, div0=1.
REQ-026 Opcodes 1100-1110 and 1111 SHALL give result=0, result_hi=0, flags=0001.
REQ-027 zero = (result==0); carry = ADD carry-out or SUB borrow, else 0; ovf = signed overflow for ADD/SUB, (result_hi!=0) for MUL, else 0; div0 as REQ-025.
REQ-028 In DONE, out_valid, result, result_hi and flags SHALL stay stable until out_ready is 1; the block then returns to IDLE on that edge, and no new request is accepted in the same cycle.
REQ-029 If alu_pwr_en is 0 at a clock edge, state SHALL go to IDLE, the iteration counter SHALL clear to 0 and out_valid SHALL clear to 0; result, result_hi and flags SHALL retain their values; an aborted operation never produces out_valid.
REQ-030 alu_pwr_en=0 SHALL override in_valid arriving in the same cycle.
REQ-031 While iso_en is 1, result, result_hi, flags, out_valid, in_ready and busy SHALL be driven to 0 combinationally, with internal state unaffected.

Reset
REQ-032 rst_n low SHALL immediately force state to IDLE, the counter to 0, all registered outputs to 0, busy to 0 and out_valid to 0, including in the middle of EXEC.
REQ-033 After reset release, in_ready SHALL be 1 on the first cycle in which alu_pwr_en is 1 and iso_en is 0.

Verification (WIDTH=16)
REQ-034 ADD a=FFFF b=0001 -> next cycle out_valid=1, result=0000, flags=0011.
REQ-035 MUL a=1234 b=0100 -> out_valid after 17 cycles, result=3400, result_hi=0012, flags=0100, busy high for 16 cycles.
REQ-036 DIV a=0064 b=0007 -> after 17 cycles result=000E, result_hi=0002; then DIV a=00AB b=0 -> next cycle result=0000, result_hi=00AB, flags=1001.
REQ-037 out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-038 alu_pwr_en dropped in the 5th EXEC cycle of MUL -> next edge busy=0, out_valid never asserted, result keeps the previous value; rst_n pulsed mid-DIV -> all outputs 0 immediately.
REQ-039 iso_en=1 while in DONE -> all listed outputs read 0; iso_en=0 -> the original response reappears unchanged.
